// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction block fills against
// load/store accesses onto a single 8-bit RAM port.
module mem_ctrl #(
  parameter int IF_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_en,
  input  logic [31:0]           if_pc,
  output logic                  if_done,
  output logic [IF_BYTES*8-1:0] if_data,
  input  logic                  lsb_en,
  input  logic                  lsb_wr,
  input  logic [1:0]            lsb_len,
  input  logic [31:0]           lsb_addr,
  input  logic [31:0]           lsb_w_data,
  output logic                  lsb_done,
  output logic [31:0]           lsb_r_data,
  input  logic                  rob_clear,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [31:0]           mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    LOAD   = 2'd2,
    STORE  = 2'd3
  } state_t;

  state_t      state_r;
  logic        last_lsb_r;
  logic [31:0] base_r;
  logic [31:0] n_r;
  logic [31:0] cnt_r;
  logic [31:0] wdata_r;
  logic [31:0] ld_buf_r;

  logic [31:0] rd_cnt_s;
  logic [31:0] wr_cnt_s;
  logic [31:0] wr_addr_s;
  logic [31:0] ld_byte_s;
  logic        grant_if_s;

  function automatic logic [31:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b00:   return 32'd1;
      2'b01:   return 32'd2;
      default: return 32'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] addr);
    return (addr[17:16] == 2'b11);
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'b00:   return w[7:0];
      2'b01:   return w[15:8];
      2'b10:   return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // Next-byte bookkeeping; a store byte counts as done only once it was actually driven.
  always_comb begin
    rd_cnt_s   = cnt_r + 32'd1;
    if (mem_wr) begin
      wr_cnt_s = cnt_r + 32'd1;
    end else begin
      wr_cnt_s = cnt_r;
    end
    wr_addr_s  = base_r + wr_cnt_s;
    ld_byte_s  = {24'd0, mem_din} << {cnt_r[1:0], 3'b000};
    grant_if_s = if_en && (!lsb_en || last_lsb_r);
  end

  // Controller state machine with registered RAM and done outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      last_lsb_r <= 1'b1;
      base_r     <= 32'd0;
      n_r        <= 32'd0;
      cnt_r      <= 32'd0;
      wdata_r    <= 32'd0;
      ld_buf_r   <= 32'd0;
      if_done    <= 1'b0;
      if_data    <= {(IF_BYTES*8){1'b0}};
      lsb_done   <= 1'b0;
      lsb_r_data <= 32'd0;
      mem_dout   <= 8'd0;
      mem_a      <= 32'd0;
      mem_wr     <= 1'b0;
    end else if (rdy) begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      case (state_r)
        IDLE: begin
          mem_wr <= 1'b0;
          // Requesters still hold their enables during the done cycle.
          if (!if_done && !lsb_done) begin
            if (grant_if_s) begin
              state_r    <= IFETCH;
              last_lsb_r <= 1'b0;
              base_r     <= if_pc;
              n_r        <= 32'(IF_BYTES);
              cnt_r      <= 32'd0;
              mem_a      <= if_pc;
            end else if (lsb_en) begin
              last_lsb_r <= 1'b1;
              base_r     <= lsb_addr;
              n_r        <= len_bytes(lsb_len);
              cnt_r      <= 32'd0;
              wdata_r    <= lsb_w_data;
              ld_buf_r   <= 32'd0;
              mem_a      <= lsb_addr;
              if (lsb_wr) begin
                state_r  <= STORE;
                mem_dout <= lsb_w_data[7:0];
                mem_wr   <= !(is_io(lsb_addr) && io_buffer_full);
              end else begin
                state_r  <= LOAD;
              end
            end
          end
        end
        IFETCH: begin
          if_data[{cnt_r[29:0], 3'b000} +: 8] <= mem_din;
          cnt_r <= rd_cnt_s;
          if (rd_cnt_s == n_r) begin
            if_done <= 1'b1;
            state_r <= IDLE;
          end else begin
            mem_a <= base_r + rd_cnt_s;
          end
        end
        LOAD: begin
          if (rob_clear) begin
            state_r <= IDLE;
          end else begin
            ld_buf_r <= ld_buf_r | ld_byte_s;
            cnt_r    <= rd_cnt_s;
            if (rd_cnt_s == n_r) begin
              lsb_r_data <= ld_buf_r | ld_byte_s;
              lsb_done   <= 1'b1;
              state_r    <= IDLE;
            end else begin
              mem_a <= base_r + rd_cnt_s;
            end
          end
        end
        STORE: begin
          cnt_r <= wr_cnt_s;
          if (wr_cnt_s == n_r) begin
            mem_wr   <= 1'b0;
            lsb_done <= 1'b1;
            state_r  <= IDLE;
          end else begin
            mem_a    <= wr_addr_s;
            mem_dout <= byte_of(wdata_r, wr_cnt_s[1:0]);
            mem_wr   <= !(is_io(wr_addr_s) && io_buffer_full);
          end
        end
        default: begin
          state_r <= IDLE;
          mem_wr  <= 1'b0;
        end
      endcase
    end
  end

endmodule
